// File: rtl/lsu_arbiter.sv
// lsu_arbiter: two-master round-robin arbiter/sequencer for the single LSU port.
// Optional lock ownership for read-modify-write sequences when LSUARB_LOCK_EN is defined.
module lsu_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic              i_m0_wren,
    input  logic              i_m1_wren,
    input  logic [2:0]        i_m0_rwsel,
    input  logic [2:0]        i_m1_rwsel,
    input  logic              i_m0_lock,
    input  logic              i_m1_lock,
    output logic              o_m0_gnt,
    output logic              o_m1_gnt,
    output logic              o_m0_rvalid,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [DATA_W-1:0] o_lsu_sdata,
    output logic              o_lsu_wren,
    output logic [2:0]        o_lsu_rwsel,
    input  logic [DATA_W-1:0] i_lsu_rdata
);
    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_last;
    logic                r_id;
    logic                r_wren;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_sdata;
    logic [2:0]          r_rwsel;
    logic                r_m0_rvalid, r_m1_rvalid;
    logic [DATA_W-1:0]   r_m0_rdata, r_m1_rdata;
    logic                w_idle, w_any, w_gnt, w_rr_pick1, w_pick1, w_load_done;

    assign w_idle      = (r_state == S_IDLE);
    assign w_any       = i_m0_req | i_m1_req;
    assign w_gnt       = w_idle & w_any;
    // On a tie the master that was not granted last wins; r_last = 1 means m1.
    assign w_rr_pick1  = i_m1_req & (~i_m0_req | ~r_last);
    assign w_load_done = (r_state == S_ACCESS) & ~r_wren;

`ifdef LSUARB_LOCK_EN
    logic r_own_vld, r_own, w_own_hold;

    assign w_own_hold = r_own_vld & (r_own ? i_m1_req : i_m0_req);
    assign w_pick1    = w_own_hold ? r_own : w_rr_pick1;

    // Ownership is taken by a locked grant and released by an unlocked grant or an idle owner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_own_vld <= 1'b0;
            r_own     <= 1'b0;
        end else if (w_gnt) begin
            r_own_vld <= w_pick1 ? i_m1_lock : i_m0_lock;
            r_own     <= w_pick1;
        end else if (w_idle && r_own_vld && !(r_own ? i_m1_req : i_m0_req)) begin
            r_own_vld <= 1'b0;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = i_m0_lock | i_m1_lock;
    assign w_pick1       = w_rr_pick1;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state: any request in IDLE starts a single ACCESS cycle.
    always_comb begin
        w_state_nxt = (w_idle && w_any) ? S_ACCESS : S_IDLE;
    end

    // FSM outputs: grants are combinational in IDLE, write enable only during ACCESS.
    always_comb begin
        o_m0_gnt   = w_gnt & ~w_pick1;
        o_m1_gnt   = w_gnt & w_pick1;
        o_lsu_wren = (r_state == S_ACCESS) & r_wren;
    end

    // Capture the whole command of the winner so fields are never mixed between masters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_wren  <= 1'b0;
            r_addr  <= '0;
            r_sdata <= '0;
            r_rwsel <= 3'b010;
        end else if (w_gnt) begin
            r_last  <= w_pick1;
            r_id    <= w_pick1;
            r_wren  <= w_pick1 ? i_m1_wren  : i_m0_wren;
            r_addr  <= w_pick1 ? i_m1_addr  : i_m0_addr;
            r_sdata <= w_pick1 ? i_m1_wdata : i_m0_wdata;
            r_rwsel <= w_pick1 ? i_m1_rwsel : i_m0_rwsel;
        end
    end

    // Load data is captured for the owning master at the end of ACCESS, with a one-cycle valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_load_done & ~r_id;
            r_m1_rvalid <= w_load_done & r_id;
            if (w_load_done && !r_id) r_m0_rdata <= i_lsu_rdata;
            if (w_load_done && r_id)  r_m1_rdata <= i_lsu_rdata;
        end
    end

    assign o_lsu_addr  = r_addr;
    assign o_lsu_sdata = r_sdata;
    assign o_lsu_rwsel = r_rwsel;
    assign o_m0_rvalid = r_m0_rvalid;
    assign o_m1_rvalid = r_m1_rvalid;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: scoreboard bench for lsu_arbiter (grant order, store pulses, load returns, reset abort).
module tb_lsu_arbiter;
    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic        w;
        logic [2:0]  s;
        logic        l;
    } cmd_t;
    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic [2:0]  s;
        int          c;
    } st_t;
    typedef struct {
        logic        id;
        logic [31:0] d;
        int          c;
    } rd_t;

    logic        clk, rst_n;
    logic        m0_req, m1_req, m0_wren, m1_wren, m0_lock, m1_lock;
    logic [11:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [2:0]  m0_rwsel, m1_rwsel;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, lsu_wren;
    logic [31:0] m0_rdata, m1_rdata, lsu_sdata, lsu_rdata;
    logic [11:0] lsu_addr;
    logic [2:0]  lsu_rwsel;

    cmd_t q0[$], q1[$];
    logic exp_gnt[$];
    st_t  exp_st[$];
    rd_t  exp_rd[$];
    int   gcyc[$];
    int   cyc, n_chk, n_pass;

    lsu_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m1_req(m1_req),
        .i_m0_addr(m0_addr), .i_m1_addr(m1_addr),
        .i_m0_wdata(m0_wdata), .i_m1_wdata(m1_wdata),
        .i_m0_wren(m0_wren), .i_m1_wren(m1_wren),
        .i_m0_rwsel(m0_rwsel), .i_m1_rwsel(m1_rwsel),
        .i_m0_lock(m0_lock), .i_m1_lock(m1_lock),
        .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt),
        .o_m0_rvalid(m0_rvalid), .o_m1_rvalid(m1_rvalid),
        .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata),
        .o_lsu_addr(lsu_addr), .o_lsu_sdata(lsu_sdata),
        .o_lsu_wren(lsu_wren), .o_lsu_rwsel(lsu_rwsel),
        .i_lsu_rdata(lsu_rdata)
    );

    function automatic logic [31:0] mem_f(input logic [11:0] a);
        return (a == 12'h004) ? 32'hDEADBEEF : {a, 20'h5A5A5};
    endfunction

    assign lsu_rdata = mem_f(lsu_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Monitor at negedge, drive masters 1 time unit after posedge.
    initial begin
        logic g0, g1, pw;
        cmd_t c;
        st_t  se;
        rd_t  re;
        cyc = 0; pw = 0;
        m0_req = 0; m1_req = 0; m0_wren = 0; m1_wren = 0; m0_lock = 0; m1_lock = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_rwsel = 0; m1_rwsel = 0;
        forever begin
            @(negedge clk);
            cyc++;
            g0 = m0_gnt; g1 = m1_gnt;
            if (g0 && g1) chk("gnt_both", 1, 0);
            if (g0 || g1) begin
                if (exp_gnt.size() == 0) chk("gnt_extra", 1, 0);
                else chk("gnt_id", {31'd0, g1}, {31'd0, exp_gnt.pop_front()});
                c = g1 ? q1[0] : q0[0];
                if (c.w) exp_st.push_back('{c.a, c.d, c.s, cyc + 1});
                else exp_rd.push_back('{g1, mem_f(c.a), cyc + 2});
                gcyc.push_back(cyc);
            end
            if (lsu_wren) begin
                chk("wren_pulse", {31'd0, pw}, 0);
                if (exp_st.size() == 0) chk("wren_spurious", 1, 0);
                else begin
                    se = exp_st.pop_front();
                    chk("st_addr", {20'd0, lsu_addr}, {20'd0, se.a});
                    chk("st_data", lsu_sdata, se.d);
                    chk("st_rwsel", {29'd0, lsu_rwsel}, {29'd0, se.s});
                    chk("st_cyc", cyc, se.c);
                end
            end
            pw = lsu_wren;
            if (m0_rvalid || m1_rvalid) begin
                chk("rv_both", {31'd0, m0_rvalid & m1_rvalid}, 0);
                if (exp_rd.size() == 0) chk("rv_extra", 1, 0);
                else begin
                    re = exp_rd.pop_front();
                    chk("rv_id", {31'd0, m1_rvalid}, {31'd0, re.id});
                    chk("rv_data", re.id ? m1_rdata : m0_rdata, re.d);
                    chk("rv_cyc", cyc, re.c);
                end
            end
            @(posedge clk);
            #1;
            if (g0 && q0.size() > 0) void'(q0.pop_front());
            if (g1 && q1.size() > 0) void'(q1.pop_front());
            m0_req = q0.size() > 0;
            if (m0_req) begin
                m0_addr = q0[0].a; m0_wdata = q0[0].d; m0_wren = q0[0].w; m0_rwsel = q0[0].s; m0_lock = q0[0].l;
            end
            m1_req = q1.size() > 0;
            if (m1_req) begin
                m1_addr = q1[0].a; m1_wdata = q1[0].d; m1_wren = q1[0].w; m1_rwsel = q1[0].s; m1_lock = q1[0].l;
            end
        end
    end

    task automatic wait_done();
        int left;
        left = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            left = q0.size() + q1.size() + exp_gnt.size() + exp_st.size() + exp_rd.size();
            if (left == 0) break;
        end
        @(negedge clk);
        chk("drain", left, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, {30'd0, m0_gnt, m1_gnt}, 0);
        chk({tag, "_rvalid"}, {30'd0, m0_rvalid, m1_rvalid}, 0);
        chk({tag, "_m0_rdata"}, m0_rdata, 0);
        chk({tag, "_m1_rdata"}, m1_rdata, 0);
        chk({tag, "_wren"}, {31'd0, lsu_wren}, 0);
        chk({tag, "_addr"}, {20'd0, lsu_addr}, 0);
        chk({tag, "_sdata"}, lsu_sdata, 0);
        chk({tag, "_rwsel"}, {29'd0, lsu_rwsel}, 32'd2);
    endtask

    initial begin
        int i;
        n_chk = 0; n_pass = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1;
        @(negedge clk);

        // m0 load from 0x004
        exp_gnt.push_back(0);
        q0.push_back('{12'h004, 32'h0, 1'b0, 3'b010, 1'b0});
        wait_done();
        chk("m0_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // m1 store to peripheral space
        exp_gnt.push_back(1);
        q1.push_back('{12'h800, 32'h12345678, 1'b1, 3'b010, 1'b0});
        wait_done();
        chk("m1_rdata_untouched", m1_rdata, 0);

        // both masters contend for 4 grants
        gcyc.delete();
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
        q0.push_back('{12'h010, 32'h0, 1'b0, 3'b010, 1'b0});
        q0.push_back('{12'h020, 32'hA0A0A0A0, 1'b1, 3'b001, 1'b0});
        q1.push_back('{12'h030, 32'h0, 1'b0, 3'b100, 1'b0});
        q1.push_back('{12'h040, 32'h0B0B0B0B, 1'b1, 3'b101, 1'b0});
        wait_done();
        chk("rr_count", gcyc.size(), 4);
        for (i = 1; i < gcyc.size(); i++) chk("rr_spacing", gcyc[i] - gcyc[i-1], 2);

        // m1 with lock for 3 accesses while m0 requests continuously
        exp_gnt.push_back(1);
`ifdef LSUARB_LOCK_EN
        exp_gnt.push_back(1); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(0);
`else
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
`endif
        q1.push_back('{12'h804, 32'h0, 1'b0, 3'b010, 1'b1});
        q1.push_back('{12'h804, 32'h55AA55AA, 1'b1, 3'b010, 1'b1});
        q1.push_back('{12'h808, 32'h0, 1'b0, 3'b010, 1'b0});
        @(negedge clk);
        q0.push_back('{12'h100, 32'h0, 1'b0, 3'b010, 1'b0});
        q0.push_back('{12'h104, 32'h77777777, 1'b1, 3'b010, 1'b0});
        wait_done();

        // reset during ACCESS of an m0 store
        exp_gnt.push_back(0);
        q0.push_back('{12'h100, 32'hCAFEF00D, 1'b1, 3'b010, 1'b0});
        for (i = 0; i < 20 && q0.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("abort_reached", q0.size(), 0);
        chk("abort_wren_before", {31'd0, lsu_wren}, 1);
        rst_n = 0;
        #1;
        chk_reset_outputs("abort");
        exp_st.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);

        // post-reset access still works
        exp_gnt.push_back(1);
        q1.push_back('{12'h004, 32'h0, 1'b0, 3'b010, 1'b0});
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-master arbiter and sequencer for the single load/store unit port. It shares the LSU between the CPU memory stage (master 0) and a second requester such as a program loader or DMA (master 1). Each access uses a req/gnt handshake and a registered command. The block pulses the LSU write enable for exactly one cycle and returns the load data to the owning master with a one-cycle valid strobe.

## Interface
- `ADDR_W`, default 12: LSU address width (bit 11 selects peripherals, bits 10:0 select memory).
- `DATA_W`, default 32: data width.
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: reset. Asynchronous, active-low.
- `m0_req`, `m1_req`, input, 1: access request, held until granted.
- `m0_addr`, `m1_addr`, input, ADDR_W: byte address.
- `m0_wdata`, `m1_wdata`, input, DATA_W: store data.
- `m0_wren`, `m1_wren`, input, 1: 1 = store, 0 = load.
- `m0_rwsel`, `m1_rwsel`, input, 3: access size/sign code, passed to the LSU unchanged.
- `m0_lock`, `m1_lock`, input, 1: keep ownership after this access. Only used when `LSUARB_LOCK_EN` is defined.
- `m0_gnt`, `m1_gnt`, output, 1: one-cycle pulse; the command was captured this cycle.
- `m0_rvalid`, `m1_rvalid`, output, 1: one-cycle pulse; `mX_rdata` is valid.
- `m0_rdata`, `m1_rdata`, output, DATA_W: load result, held until that master's next rvalid.
- `lsu_addr`, output, ADDR_W: address to the LSU.
- `lsu_sdata`, output, DATA_W: store data to the LSU.
- `lsu_wren`, output, 1: write enable to the LSU.
- `lsu_rwsel`, output, 3: size/sign code to the LSU.
- `lsu_rdata`, input, DATA_W: combinational read data from the LSU.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - ACCESS: one cycle in which the registered command drives the LSU.
- IDLE with any request:
  - pick a winner;
  - assert `mX_gnt` for that cycle (combinational from req and state);
  - register the winner's addr, wdata, wren, rwsel and id;
  - go to ACCESS.
- IDLE with no request: stay in IDLE; all gnt outputs 0.
- ACCESS:
  - `lsu_addr`, `lsu_sdata` and `lsu_rwsel` come from the command register;
  - `lsu_wren` = registered wren for this one cycle only;
  - `lsu_rdata` is captured into the owner's `mX_rdata` at the closing edge, for loads only;
  - always return to IDLE.
- After a load's ACCESS cycle, the owner's `mX_rvalid` = 1 for exactly one cycle (the cycle following ACCESS). A store produces no rvalid.
- Round-robin winner selection:
  - `last` flop holds the id of the most recent grant;
  - if both masters request, grant the one ≠ `last`;
  - if one master requests, grant it;
  - `last` updates on every grant.
- Outside ACCESS: `lsu_wren` = 0, and `lsu_addr`/`lsu_sdata`/`lsu_rwsel` hold their last values.
- Master 0 and master 1 commands are never mixed; all fields of a command come from the same master.
- A master may change its command inputs or drop req in the cycle after its gnt.

## Timing
- Reset values (async assert):
  - state = IDLE, `last` = 1 (master 0 wins the first tie);
  - all gnt = 0, all rvalid = 0, all rdata = 0;
  - `lsu_wren` = 0, `lsu_addr` = 0, `lsu_sdata` = 0, `lsu_rwsel` = 3'b010.
- Cycle N: gnt. Cycle N+1: ACCESS. Cycle N+2: rvalid (loads only), and the next gnt may occur in the same cycle.
- Peak throughput: one access per 2 cycles.
- A request arriving during ACCESS is considered only in the following IDLE.
- Reset asserted mid-ACCESS:
  - the access is aborted, `lsu_wren` drops immediately and no rvalid is issued;
  - a store may or may not have committed.
- Simultaneous requests with lock ownership active (macro on): the owner wins regardless of `last`.

## Configuration
- `LSUARB_LOCK_EN` defined:
  - if `mX_lock` = 1 when that master is granted, it becomes owner;
  - in later IDLE cycles only the owner can be granted while its req = 1;
  - ownership ends on a grant with `mX_lock` = 0, or on an IDLE cycle where the owner's req = 0;
  - intended for read-modify-write sequences on peripheral registers.
- `LSUARB_LOCK_EN` undefined: `mX_lock` is ignored, there is no owner flop, and arbitration is pure round-robin.

## Test plan
- Reset release, m0 load `addr` = 0x004, `lsu_rdata` = 0xDEADBEEF → `m0_gnt` at N, `lsu_wren` = 0 at N+1, `m0_rvalid` = 1 and `m0_rdata` = 0xDEADBEEF at N+2; `m1_rvalid` stays 0.
- m1 store `addr` = 0x800, `wdata` = 0x12345678, `rwsel` = 010 → `lsu_wren` = 1 for exactly one cycle with `lsu_addr` = 0x800 and `lsu_sdata` = 0x12345678; no rvalid.
- Both masters hold req for 4 grants → grant order m0, m1, m0, m1, with gnts 2 cycles apart.
- Reset asserted during ACCESS of an m0 store → `lsu_wren` drops in the same cycle; all outputs take reset values; no rvalid.
- `LSUARB_LOCK_EN` on: m1 holds lock = 1 for 3 accesses while m0 requests continuously → m1 is granted 3 times in a row; m0 is granted after m1's grant with lock = 0.
- `LSUARB_LOCK_EN` off: same stimulus as the previous scenario → strict alternation between masters.
